// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined WIDTH-bit barrel shifter with valid/ready on
// both sides. One mux level per shift-amount bit (largest first), each level
// followed by a register. The whole pipe freezes while the output is held.
// Optional feature macro: BARREL_SHIFTER_PIPE_CARRY_EN builds the carry path;
// without it c is tied low.

// One shift level: conditionally shifts by SHIFT, then registers the result.
module barrel_shifter_stage #(
  parameter int WIDTH = 64,
  parameter int TAGW  = 4,
  parameter int SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             src_vld,
  input  logic [WIDTH-1:0] src_data,
  input  logic [TAGW-1:0]  src_tag,
  input  logic             src_en,
  input  logic             src_dir,
  input  logic             src_rot,
  input  logic             src_fill,
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
  input  logic             src_c,
  output logic             dst_c,
`endif
  output logic             dst_vld,
  output logic [WIDTH-1:0] dst_data,
  output logic [TAGW-1:0]  dst_tag
);
  logic [WIDTH-1:0] wrap, res;

  // Shift by SHIFT when this level's amount bit is set; the vacated end is
  // filled with rotated-out bits, the sign (arith right) or zero.
  always_comb begin
    if (src_rot)
      wrap = src_dir ? (src_data << (WIDTH - SHIFT)) : (src_data >> (WIDTH - SHIFT));
    else
      wrap = src_dir ? ({WIDTH{src_fill}} << (WIDTH - SHIFT)) : '0;
    res = src_data;
    if (src_en)
      res = (src_dir ? (src_data >> SHIFT) : (src_data << SHIFT)) | wrap;
  end

  // Level register; holds (bubbles included) whenever the pipe is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_vld  <= 1'b0;
      dst_data <= '0;
      dst_tag  <= '0;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
      dst_c    <= 1'b0;
`endif
    end else if (adv) begin
      dst_vld  <= src_vld;
      dst_data <= res;
      dst_tag  <= src_tag;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
      dst_c    <= src_c;
`endif
    end
  end
endmodule

module barrel_shifter_pipe #(
  parameter int WIDTH = 64,
  parameter int TAGW  = 4,
  localparam int SW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d_in,
  input  logic [SW-1:0]    sh_amt,
  input  logic             dir,
  input  logic [1:0]       op,
  input  logic [TAGW-1:0]  tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_out,
  output logic [TAGW-1:0]  tag_out,
  output logic             z,
  output logic             n,
  output logic             c
);
  logic                    stall, adv;
  logic [SW:0]             vld_pipe;
  logic [SW:0][WIDTH-1:0]  data_p;
  logic [SW:0][TAGW-1:0]   tag_p;
  // Per-level control: index 0 is the input, higher indices are registered.
  logic [SW-1:0]           lv_dir, lv_rot, lv_fill;
  logic [SW-2:0]           dir_q, rot_q, fill_q;

  assign stall     = vld_pipe[SW] && !out_ready;
  assign adv       = !stall;
  assign in_ready  = !stall;

  assign vld_pipe[0] = in_valid;
  assign data_p[0]   = d_in;
  assign tag_p[0]    = tag_in;

  // op 11 decodes as logical; the arithmetic fill is folded into one bit.
  assign lv_dir  = {dir_q, dir};
  assign lv_rot  = {rot_q, (op == 2'b10)};
  assign lv_fill = {fill_q, (dir && (op == 2'b01) && d_in[WIDTH-1])};

  // Control shift register feeding levels 1..SW-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q  <= '0;
      rot_q  <= '0;
      fill_q <= '0;
    end else if (adv) begin
      dir_q  <= lv_dir[SW-2:0];
      rot_q  <= lv_rot[SW-2:0];
      fill_q <= lv_fill[SW-2:0];
    end
  end

`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
  logic [SW:0]   c_p;
  logic [SW-1:0] idx_l, idx_r;

  // Carry is the last bit shifted/rotated out; for rotates this equals the
  // result LSB (left) or MSB (right), so one formula covers every mode.
  always_comb begin
    idx_r  = sh_amt - SW'(1);
    idx_l  = -sh_amt;
    c_p[0] = (sh_amt == '0) ? 1'b0 : (dir ? d_in[idx_r] : d_in[idx_l]);
  end
  assign c = c_p[SW];
`else
  assign c = 1'b0;
`endif

  for (genvar k = 0; k < SW; k++) begin : g_lvl
    // Only the not-yet-consumed amount bits travel down the pipe.
    logic [SW-1-k:0] amt_in;
    if (k == 0) begin : g_src
      assign amt_in = sh_amt;
    end else begin : g_src
      assign amt_in = g_lvl[k-1].g_reg.amt_q;
    end

    if (k < SW-1) begin : g_reg
      logic [SW-2-k:0] amt_q;
      // Remaining shift-amount bits for the following levels.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   amt_q <= '0;
        else if (adv) amt_q <= amt_in[SW-2-k:0];
      end
    end

    barrel_shifter_stage #(
      .WIDTH (WIDTH),
      .TAGW  (TAGW),
      .SHIFT (1 << (SW-1-k))
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv),
      .src_vld  (vld_pipe[k]),
      .src_data (data_p[k]),
      .src_tag  (tag_p[k]),
      .src_en   (amt_in[SW-1-k]),
      .src_dir  (lv_dir[k]),
      .src_rot  (lv_rot[k]),
      .src_fill (lv_fill[k]),
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
      .src_c    (c_p[k]),
      .dst_c    (c_p[k+1]),
`endif
      .dst_vld  (vld_pipe[k+1]),
      .dst_data (data_p[k+1]),
      .dst_tag  (tag_p[k+1])
    );
  end

  assign out_valid = vld_pipe[SW];
  assign d_out     = data_p[SW];
  assign tag_out   = tag_p[SW];
  assign z         = (data_p[SW] == '0);
  assign n         = data_p[SW][WIDTH-1];
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe (WIDTH=64, TAGW=4). Carry
// expectations follow BARREL_SHIFTER_PIPE_CARRY_EN: zero when undefined.
module tb_barrel_shifter_pipe;
  localparam int WIDTH = 64;
  localparam int TAGW  = 4;
  localparam int SW    = 6;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
  localparam logic CE = 1'b1;
`else
  localparam logic CE = 1'b0;
`endif

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             in_valid = 1'b0, in_ready, dir = 1'b0;
  logic             out_valid, out_ready = 1'b1, z, n, c;
  logic [WIDTH-1:0] d_in = '0, d_out;
  logic [SW-1:0]    sh_amt = '0;
  logic [1:0]       op = '0;
  logic [TAGW-1:0]  tag_in = '0, tag_out;

  int checks = 0, errors = 0;

  barrel_shifter_pipe #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .d_in(d_in), .sh_amt(sh_amt), .dir(dir), .op(op), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out),
    .tag_out(tag_out), .z(z), .n(n), .c(c)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  // Issue one op at a negedge and check it emerges exactly SW cycles later.
  task automatic run_op(input string nm, input logic [63:0] din, input logic [5:0] amt,
                        input logic dr, input logic [1:0] o, input logic [3:0] tg,
                        input logic [63:0] exp_d, input logic exp_c);
    d_in = din; sh_amt = amt; dir = dr; op = o; tag_in = tg; in_valid = 1'b1;
    #1 check({nm, " in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; d_in = '0; sh_amt = '0; tag_in = '0;
    repeat (SW-2) @(negedge clk);
    check({nm, " early"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({nm, " valid"}, 64'(out_valid), 64'd1);
    check({nm, " d_out"}, d_out, exp_d);
    check({nm, " c"},     64'(c), 64'(exp_c & CE));
    check({nm, " z"},     64'(z), 64'(exp_d == 64'd0));
    check({nm, " n"},     64'(n), 64'(exp_d[63]));
    check({nm, " tag"},   64'(tag_out), 64'(tg));
    @(negedge clk);
  endtask

  int sent, recv, extra;
  logic was_stall, hold_c;
  logic [63:0] hold_d;
  logic [3:0]  hold_t;

  initial begin
    // Reset state
    #2;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst d_out",     d_out, 64'd0);
    check("rst tag_out",   64'(tag_out), 64'd0);
    check("rst z",         64'(z), 64'd1);
    check("rst n",         64'(n), 64'd0);
    check("rst c",         64'(c), 64'd0);
    check("rst in_ready",  64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed single ops
    run_op("ll1",   64'h8000_0000_0000_0001, 6'd1,  1'b0, 2'b00, 4'd3, 64'h0000_0000_0000_0002, 1'b1);
    run_op("ar4",   64'hF000_0000_0000_0000, 6'd4,  1'b1, 2'b01, 4'd5, 64'hFF00_0000_0000_0000, 1'b0);
    run_op("lr4",   64'hF000_0000_0000_0000, 6'd4,  1'b1, 2'b00, 4'd6, 64'h0F00_0000_0000_0000, 1'b0);
    run_op("rr8",   64'h0000_0000_0000_00AB, 6'd8,  1'b1, 2'b10, 4'd7, 64'hAB00_0000_0000_0000, 1'b1);
    run_op("rl4",   64'hF000_0000_0000_0001, 6'd4,  1'b0, 2'b10, 4'd8, 64'h0000_0000_0000_001F, 1'b1);
    run_op("rot0",  64'h1234_5678_9ABC_DEF0, 6'd0,  1'b1, 2'b10, 4'd9, 64'h1234_5678_9ABC_DEF0, 1'b0);
    run_op("ar0",   64'h8765_4321_0FED_CBA9, 6'd0,  1'b1, 2'b01, 4'd1, 64'h8765_4321_0FED_CBA9, 1'b0);
    run_op("zero",  64'h0000_0000_0000_0000, 6'd5,  1'b0, 2'b00, 4'd2, 64'h0000_0000_0000_0000, 1'b0);
    run_op("ll63",  64'h0000_0000_0000_0003, 6'd63, 1'b0, 2'b00, 4'd4, 64'h8000_0000_0000_0000, 1'b1);
    run_op("op11",  64'h8000_0000_0000_0001, 6'd1,  1'b1, 2'b11, 4'd10, 64'h4000_0000_0000_0000, 1'b1);
    run_op("al2",   64'hC000_0000_0000_0001, 6'd2,  1'b0, 2'b01, 4'd11, 64'h0000_0000_0000_0004, 1'b1);
    run_op("ar63",  64'h8000_0000_0000_0000, 6'd63, 1'b1, 2'b01, 4'd12, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // Back-pressure: 10 ops tagged 0..9, out_ready low on cycles 8..10
    sent = 0; recv = 0; was_stall = 1'b0;
    hold_d = '0; hold_t = '0; hold_c = 1'b0;
    for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
      in_valid = (sent < 10); d_in = 64'(sent); tag_in = 4'(sent);
      sh_amt = 6'd1; dir = 1'b0; op = 2'b00;
      out_ready = !(cyc >= 8 && cyc <= 10);
      #1;
      if (was_stall) begin
        check("bp hold d_out", d_out, hold_d);
        check("bp hold tag",   64'(tag_out), 64'(hold_t));
        check("bp hold c",     64'(c), 64'(hold_c));
      end
      if (cyc >= 8 && cyc <= 10) begin
        check("bp stall valid",    64'(out_valid), 64'd1);
        check("bp stall in_ready", 64'(in_ready), 64'd0);
      end else begin
        check("bp free in_ready", 64'(in_ready), 64'd1);
      end
      if (out_valid && out_ready) begin
        check("bp order tag", 64'(tag_out), 64'(recv));
        check("bp data",      d_out, 64'(recv) << 1);
        recv++;
      end
      was_stall = out_valid && !out_ready;
      hold_d = d_out; hold_t = tag_out; hold_c = c;
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp count", 64'(recv), 64'd10);
    extra = 0;
    repeat (8) begin
      #1 if (out_valid) extra++;
      @(negedge clk);
    end
    check("bp no dup", 64'(extra), 64'd0);

    // Reset mid-flight: 4 ops in the pipe, the oldest at the output
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; d_in = 64'(i + 1); tag_in = 4'(i + 1); sh_amt = 6'd0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("mid valid before rst", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid rst out_valid", 64'(out_valid), 64'd0);
    check("mid rst d_out",     d_out, 64'd0);
    check("mid rst z",         64'(z), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (10) begin
      #1 if (out_valid) extra++;
      @(negedge clk);
    end
    check("mid no stale", 64'(extra), 64'd0);
    run_op("post rst", 64'h0000_0000_0000_0081, 6'd1, 1'b1, 2'b10, 4'd14, 64'h8000_0000_0000_0040, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, pipelined barrel shifter with a valid/ready handshake on both sides. It does logical, arithmetic and rotate shifts in either direction and produces zero, negative and carry-out flags. It sits in the datapath wherever a shift must meet timing at full clock rate and accept back-pressure from downstream. It is the pipelined, width-generic successor to the team's combinational 64-bit shifter.

## Interface
- WIDTH, 64: data width. Power of two, ≥ 8. SW = log2(WIDTH).
- TAGW, 4: width of the opaque tag carried alongside each operation.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an input this cycle.
- d_in  in  WIDTH  operand.
- sh_amt  in  SW  shift amount, 0..WIDTH-1.
- dir  in  1  0 = left, 1 = right.
- op  in  2  00 logical, 01 arithmetic, 10 rotate, 11 treated as 00.
- tag_in  in  TAGW  returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- d_out  out  WIDTH  shifted result.
- tag_out  out  TAGW  tag of the current result.
- z  out  1  d_out == 0.
- n  out  1  d_out[WIDTH-1].
- c  out  1  carry-out: last bit shifted or rotated out.

## Operation
- Pipeline structure:
  - SW mux levels, largest shift first (2^(SW-1) down to 1).
  - A register follows every level: stage k holds data, the remaining sh_amt bits, dir, op, tag, carry and a valid bit.
- Arithmetic fill:
  - Applies only when dir = 1 and op = 01. The vacated MSBs fill with the original d_in[WIDTH-1].
  - Arithmetic left is identical to logical left.
- Rotate: vacated bits take the bits shifted out of the opposite end.
- Carry, for sh_amt = s > 0:
  - left shift: d_in[WIDTH-s].
  - right shift: d_in[s-1].
  - rotate left: result LSB.
  - rotate right: result MSB.
  - s = 0: c = 0 in all modes.
  - Carry is computed from d_in at stage 0 and piped with the data.
- Flags:
  - z and n are derived combinationally from the final stage register.
  - All flags are valid only while out_valid = 1.
- Handshake:
  - An input transfer happens when in_valid && in_ready.
  - An output transfer happens when out_valid && out_ready.
- Stall:
  - stall = out_valid && !out_ready.
  - While stall is high, every stage holds its contents, including bubbles.
  - in_ready = !stall.
  - When no stall is present, all stages advance every cycle and bubbles propagate as valid = 0.
- Ordering:
  - Results emerge strictly in input order.
  - No operation is dropped or duplicated.
- Output stability: while out_valid = 1 and out_ready = 0, d_out, tag_out, z, n and c stay stable.

## Timing
- Latency: SW cycles from the input transfer to out_valid, with no stalls (6 for WIDTH = 64).
- Throughput: one operation per cycle when out_ready is held at 1.
- in_ready is a combinational function of out_valid and out_ready; it has no path from in_valid.
- Reset values (asynchronous, applied immediately on rst_n low):
  - All valid bits 0, so out_valid = 0.
  - d_out = 0 and tag_out = 0, so z = 1, n = 0, c = 0.
  - in_ready = 1 whenever out_valid = 0.
- Reset mid-operation: every in-flight operation is discarded. No partial result appears after rst_n is released.
- The first input can be accepted on the first rising edge after rst_n deasserts.
- Simultaneous output and input transfer in the same cycle is legal and required for full throughput.

## Configuration
- BARREL_SHIFTER_PIPE_CARRY_EN:
  - Defined: the carry logic and its per-stage carry register are built, and c behaves as specified above.
  - Undefined: no carry logic or carry registers exist, and c is tied to 0. All other behaviour and the latency are unchanged.

## Test plan
WIDTH = 64, TAGW = 4, macro defined unless stated.
- Logical left: d_in=0x8000_0000_0000_0001, sh_amt=1, dir=0, op=00, tag=3 → after 6 cycles d_out=0x0000_0000_0000_0002, c=1, z=0, n=0, tag_out=3.
- Arithmetic right: d_in=0xF000_0000_0000_0000, sh_amt=4, dir=1, op=01 → d_out=0xFF00_0000_0000_0000, n=1, c=0. The same input with op=00 → d_out=0x0F00_0000_0000_0000, n=0.
- Rotate right: d_in=0x0000_0000_0000_00AB, sh_amt=8, op=10 → d_out=0xAB00_0000_0000_0000, c=1.
  - sh_amt=0 on any mode → d_out=d_in, c=0.
  - d_in=0 → z=1.
- Back-pressure: 10 back-to-back ops tagged 0..9, out_ready held low for 3 cycles mid-stream.
  - in_ready falls in the same cycle that out_valid is high with out_ready low.
  - All 10 results arrive in tag order with no loss or duplication.
  - Outputs stay stable during the stall.
- Reset mid-flight: 4 ops in the pipe, pulse rst_n low for 1 cycle.
  - out_valid drops immediately.
  - No stale result appears afterward.
  - A new op issued after reset returns after 6 cycles.
- Macro undefined: rerun the logical-left test → d_out identical, c=0.
